// File: rtl/tartaruga_dmem_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
// Signal names keep the responder-side direction suffixes so both ends read the same way.
interface tartaruga_dmem_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );
endinterface

// File: rtl/tartaruga_dmem.sv
// Word data memory with one outstanding request and fixed latency for the MEM stage.
// Define TARTARUGA_DMEM_ERR_EN to flag misaligned or out-of-range accesses on rsp_err_o.
module tartaruga_dmem #(
   parameter int unsigned DMEM_POS = 4096,
   parameter int unsigned LATENCY  = 2
) (
   input logic              clk_i,
   input logic              rst_i,
   tartaruga_dmem_if.slave  bus
);
   localparam int unsigned AW = (DMEM_POS > 1) ? $clog2(DMEM_POS) : 1;
   localparam int unsigned CW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q;
   logic [31:0]     addr_q, wdata_q;
   logic [31:0]     rdata_q;
   logic            err_q;
   logic            accept, commit;
   logic            c_we, c_err;
   logic [31:0]     c_addr, c_wdata;
   logic [AW-1:0]   c_idx;
   logic [31:0]     mem [DMEM_POS];

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      accept          = 1'b0;
      commit          = 1'b0;
      bus.req_ready_o = 1'b0;
      bus.rsp_valid_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.req_ready_o = ~rst_i;
            if (bus.req_valid_i && !rst_i) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  state_d = StResp;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = CW'(LATENCY - 1);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = StResp;
               commit  = 1'b1;
            end
         end
         StResp: begin
            bus.rsp_valid_o = 1'b1;
            if (bus.rsp_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // With LATENCY==1 the commit edge is the accept edge, so use the live request.
   always_comb begin
      c_we    = (state_q == StIdle) ? bus.req_we_i    : we_q;
      c_addr  = (state_q == StIdle) ? bus.req_addr_i  : addr_q;
      c_wdata = (state_q == StIdle) ? bus.req_wdata_i : wdata_q;
      c_idx   = c_addr[AW+1:2];
   end

`ifdef TARTARUGA_DMEM_ERR_EN
   assign c_err = (c_addr[1:0] != 2'b00) || ({2'b00, c_addr[31:2]} >= DMEM_POS);
`else
   logic unused_addr;
   assign c_err       = 1'b0;
   assign unused_addr = ^{c_addr[1:0], c_addr[31:AW+2]};
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            we_q    <= bus.req_we_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
         end
         if (commit) begin
            rdata_q <= (c_we || c_err) ? 32'h0 : mem[c_idx];
            err_q   <= c_err;
         end
      end
   end

   // Array has no reset; a dropped request never reaches the commit edge.
   always_ff @(posedge clk_i) begin
      if (commit && c_we && !c_err) mem[c_idx] <= c_wdata;
   end

   assign bus.rsp_rdata_o = rdata_q;
   assign bus.rsp_err_o   = err_q;
endmodule

// File: tb/tb_tartaruga_dmem.sv
// Randomised bench for tartaruga_dmem against an associative-array memory model.
// Instance a: LATENCY=2, DMEM_POS=4096; instance b: LATENCY=1, DMEM_POS=16 for back-to-back accepts.
module tb_tartaruga_dmem;
   localparam int unsigned LAT_A = 2;
   localparam int unsigned POS_A = 4096;
   localparam int unsigned POS_B = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] ref_a [int];
   logic [31:0] ref_b [int];

   tartaruga_dmem_if a ();
   tartaruga_dmem_if b ();

   tartaruga_dmem #(.DMEM_POS(POS_A), .LATENCY(LAT_A)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a));
   tartaruga_dmem #(.DMEM_POS(POS_B), .LATENCY(1))     dut_b (.clk_i(clk), .rst_i(rst), .bus(b));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_err(input logic [31:0] addr, input int unsigned pos);
`ifdef TARTARUGA_DMEM_ERR_EN
      return (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(pos));
`else
      return (addr === 32'hx) && (pos == 0);
`endif
   endfunction

   // One full transaction on instance a with bp cycles of response backpressure.
   task automatic xact_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int bp);
      int          n;
      int          idx;
      bit          err;
      bit          known;
      logic [31:0] exp;
      idx   = int'((addr >> 2) % POS_A);
      err   = model_err(addr, POS_A);
      known = 1'b1;
      exp   = 32'h0;
      if (!we && !err) begin
         if (ref_a.exists(idx)) exp = ref_a[idx];
         else known = 1'b0;
      end
      if (we && !err) ref_a[idx] = wdata;
      @(negedge clk);
      a.req_valid_i = 1'b1;
      a.req_we_i    = we;
      a.req_addr_i  = addr;
      a.req_wdata_i = wdata;
      a.rsp_ready_i = 1'b0;
      n = 0;
      while (!a.req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("a_req_ready_idle", 32'(a.req_ready_o), 32'd1);
      @(negedge clk);
      // Garbage on the request side while busy must be ignored.
      a.req_valid_i = 1'($urandom);
      a.req_we_i    = 1'($urandom);
      a.req_addr_i  = $urandom;
      a.req_wdata_i = $urandom;
      n = 1;
      while (!a.rsp_valid_o && n < 20) begin
         check_eq("a_req_ready_busy", 32'(a.req_ready_o), 32'd0);
         @(negedge clk);
         n++;
      end
      check_eq("a_latency", 32'(n), 32'(LAT_A));
      if (known) check_eq("a_rdata", a.rsp_rdata_o, exp);
      check_eq("a_err", 32'(a.rsp_err_o), 32'(err));
      repeat (bp) begin
         @(negedge clk);
         check_eq("a_bp_valid", 32'(a.rsp_valid_o), 32'd1);
         check_eq("a_bp_req_ready", 32'(a.req_ready_o), 32'd0);
         if (known) check_eq("a_bp_rdata", a.rsp_rdata_o, exp);
      end
      a.rsp_ready_i = 1'b1;
      @(negedge clk);
      a.rsp_ready_i = 1'b0;
      a.req_valid_i = 1'b0;
      check_eq("a_rsp_done", 32'(a.rsp_valid_o), 32'd0);
      check_eq("a_req_ready_after", 32'(a.req_ready_o), 32'd1);
   endtask

   // Instance b keeps req_valid and rsp_ready high; an accept is expected every second cycle.
   task automatic op_b(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      int          idx;
      bit          err;
      logic [31:0] exp;
      idx = int'((addr >> 2) % POS_B);
      err = model_err(addr, POS_B);
      exp = (we || err || !ref_b.exists(idx)) ? 32'h0 : ref_b[idx];
      if (we && !err) ref_b[idx] = wdata;
      @(negedge clk);
      b.req_valid_i = 1'b1;
      b.rsp_ready_i = 1'b1;
      b.req_we_i    = we;
      b.req_addr_i  = addr;
      b.req_wdata_i = wdata;
      check_eq("b_req_ready", 32'(b.req_ready_o), 32'd1);
      @(negedge clk);
      check_eq("b_rsp_valid", 32'(b.rsp_valid_o), 32'd1);
      check_eq("b_req_ready_busy", 32'(b.req_ready_o), 32'd0);
      check_eq("b_rdata", b.rsp_rdata_o, exp);
      check_eq("b_err", 32'(b.rsp_err_o), 32'(err));
   endtask

   initial begin
      logic [31:0] addr;
      a.req_valid_i = 1'b0; a.req_we_i = 1'b0; a.req_addr_i = '0; a.req_wdata_i = '0;
      a.rsp_ready_i = 1'b0;
      b.req_valid_i = 1'b0; b.req_we_i = 1'b0; b.req_addr_i = '0; b.req_wdata_i = '0;
      b.rsp_ready_i = 1'b0;
      #12;
      check_eq("rst_req_ready", 32'(a.req_ready_o), 32'd0);
      check_eq("rst_rsp_valid", 32'(a.rsp_valid_o), 32'd0);
      check_eq("rst_rdata", a.rsp_rdata_o, 32'h0);
      check_eq("rst_err", 32'(a.rsp_err_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_release_ready", 32'(a.req_ready_o), 32'd1);

      for (int i = 0; i < 9; i++) xact_a(1'b1, 32'(i * 4), $urandom, 0);
      xact_a(1'b1, 32'h10, 32'hDEADBEEF, 0);
      xact_a(1'b0, 32'h10, 32'h0, 5);
      xact_a(1'b1, 32'h20, 32'h5555, 1);

      // Reset while the store to 0x20 sits in WAIT: it must vanish.
      @(negedge clk);
      a.req_valid_i = 1'b1; a.req_we_i = 1'b1; a.req_addr_i = 32'h20; a.req_wdata_i = 32'h1;
      @(negedge clk);
      a.req_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("midrst_req_ready", 32'(a.req_ready_o), 32'd0);
      check_eq("midrst_rsp_valid", 32'(a.rsp_valid_o), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check_eq("midrst_no_rsp", 32'(a.rsp_valid_o), 32'd0);
      end
      xact_a(1'b0, 32'h20, 32'h0, 0);

      xact_a(1'b0, 32'h3, 32'h0, 0);
      xact_a(1'b1, 32'h4000, 32'hA5, 0);
      xact_a(1'b0, 32'h0, 32'h0, 2);

      for (int i = 0; i < 40; i++) begin
         addr = 32'($urandom_range(0, 8) * 4) + 32'($urandom_range(0, 2) * POS_A * 4)
                + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
         xact_a(1'($urandom), addr, $urandom, $urandom_range(0, 3));
      end

      for (int i = 0; i < int'(POS_B); i++) op_b(1'b1, 32'(i * 4), $urandom);
      for (int i = 0; i < 24; i++) op_b(1'($urandom), 32'($urandom_range(0, 255)), $urandom);
      @(negedge clk);
      b.req_valid_i = 1'b0;
      b.rsp_ready_i = 1'b0;
      @(negedge clk);
      check_eq("b_idle_end", 32'(b.rsp_valid_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors",
               n_checks, n_errors);
      $fatal(1, "timeout");
   end
endmodule
